// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if
// Groups the alarm sequencer's command, sensor and timer-tick inputs with its
// timer-control, siren and status outputs. The sequencer connects through the
// slave modport; whatever drives commands and sensors uses the master modport.
//   tick/armCmd/disarmCmd : one-cycle pulses into the sequencer
//   sensors               : raw, asynchronous zone inputs (active-high = tripped)
//   tmrEN/tmrRST          : control of the upstream tick timer
//   siren/armedLed/alarmMem/armFail/state/remaining : status outputs
interface alarm_sequencer_if #(
    parameter int NSENS = 4
);
    logic             tick;
    logic             armCmd;
    logic             disarmCmd;
    logic [NSENS-1:0] sensors;
    logic             tmrEN;
    logic             tmrRST;
    logic             siren;
    logic             armedLed;
    logic             alarmMem;
    logic             armFail;
    logic [2:0]       state;
    logic [7:0]       remaining;

    modport master (
        output tick, armCmd, disarmCmd, sensors,
        input  tmrEN, tmrRST, siren, armedLed, alarmMem, armFail, state, remaining
    );

    modport slave (
        input  tick, armCmd, disarmCmd, sensors,
        output tmrEN, tmrRST, siren, armedLed, alarmMem, armFail, state, remaining
    );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
// Arming/alarm state machine driven by timer ticks. Sequences DISARMED, EXIT,
// ARMED, ENTRY and ALARM, measures each delay by counting ticks, and drives the
// timer enable/restart, siren, armed LED, alarm memory and arm-refused pulse.
// Ports:
//   clkSignal : system clock, rising edge
//   RST       : asynchronous, active-high reset
//   bus       : alarm_sequencer_if slave (commands, sensors, tick, status)
module alarm_sequencer #(
    parameter int               NSENS       = 4,
    parameter logic [NSENS-1:0] DELAY_MASK  = 4'b0001,
    parameter logic [7:0]       EXIT_TICKS  = 8'd30,
    parameter logic [7:0]       ENTRY_TICKS = 8'd15,
    parameter logic [7:0]       SIREN_TICKS = 8'd180
) (
    input logic               clkSignal,
    input logic               RST,
    alarm_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             tmr_rst_q, tmr_rst_d;
    logic             alarm_mem_q, alarm_mem_d;
    logic             arm_fail_q, arm_fail_d;
    logic [NSENS-1:0] sync1_q, sz_q;

    logic [7:0]       limit_s;
    logic             timed_s;
    logic             count_ok_s;
    logic             expire_s;
    logic             inst_trip_s;
    logic             del_trip_s;
    logic             any_trip_s;

    // Two-flop synchronizer for the asynchronous zone inputs.
    always_ff @(posedge clkSignal or posedge RST) begin
        if (RST) begin
            sync1_q <= {NSENS{1'b0}};
            sz_q    <= {NSENS{1'b0}};
        end else begin
            sync1_q <= bus.sensors;
            sz_q    <= sync1_q;
        end
    end

    assign inst_trip_s = |(sz_q & ~DELAY_MASK);
    assign del_trip_s  = |(sz_q & DELAY_MASK);
    assign any_trip_s  = |sz_q;

    // Per-state tick limit; zero limit marks an untimed state.
    always_comb begin
        limit_s = 8'd0;
        timed_s = 1'b0;
        case (state_q)
            S_EXIT:  begin limit_s = EXIT_TICKS;  timed_s = 1'b1; end
            S_ENTRY: begin limit_s = ENTRY_TICKS; timed_s = 1'b1; end
            S_ALARM: begin limit_s = SIREN_TICKS; timed_s = 1'b1; end
            default: begin limit_s = 8'd0;        timed_s = 1'b0; end
        endcase
    end

    // A tick in the restart cycle belongs to the timer's old period, so it is
    // not counted; the cnt<limit guard keeps the counter from ever wrapping.
    assign count_ok_s = bus.tick && timed_s && !tmr_rst_q && (cnt_q < limit_s);
    assign expire_s   = count_ok_s && ((cnt_q + 8'd1) == limit_s);

    // Next-state logic: disarm beats sensors, sensors beat tick expiry.
    always_comb begin
        state_d     = state_q;
        arm_fail_d  = 1'b0;
        alarm_mem_d = alarm_mem_q;
        case (state_q)
            S_DISARMED: begin
                if (bus.armCmd && !bus.disarmCmd) begin
                    if (!any_trip_s) begin
                        state_d     = S_EXIT;
                        alarm_mem_d = 1'b0;
                    end else begin
                        arm_fail_d = 1'b1;
                    end
                end else begin
                    state_d = S_DISARMED;
                end
            end
            S_EXIT: begin
                if (bus.disarmCmd)  state_d = S_DISARMED;
                else if (expire_s)  state_d = S_ARMED;
                else                state_d = S_EXIT;
            end
            S_ARMED: begin
                if (bus.disarmCmd)       state_d = S_DISARMED;
                else if (inst_trip_s)    state_d = S_ALARM;
                else if (del_trip_s)     state_d = S_ENTRY;
                else                     state_d = S_ARMED;
            end
            S_ENTRY: begin
                if (bus.disarmCmd)                state_d = S_DISARMED;
                else if (inst_trip_s || expire_s) state_d = S_ALARM;
                else                              state_d = S_ENTRY;
            end
            S_ALARM: begin
                if (bus.disarmCmd)  state_d = S_DISARMED;
                else if (expire_s)  state_d = S_ARMED;
                else                state_d = S_ALARM;
            end
            default: state_d = S_DISARMED;
        endcase

        if (state_d == S_ALARM) begin
            alarm_mem_d = 1'b1;
        end else begin
            alarm_mem_d = alarm_mem_d;
        end
    end

    // Counter restarts on any state change; timer restart pulses on entry to
    // every timed state, including ENTRY -> ALARM.
    always_comb begin
        cnt_d     = cnt_q;
        tmr_rst_d = 1'b0;
        if (state_d != state_q) begin
            cnt_d     = 8'd0;
            tmr_rst_d = (state_d == S_EXIT) || (state_d == S_ENTRY) || (state_d == S_ALARM);
        end else if (count_ok_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and status registers.
    always_ff @(posedge clkSignal or posedge RST) begin
        if (RST) begin
            state_q     <= S_DISARMED;
            cnt_q       <= 8'd0;
            tmr_rst_q   <= 1'b0;
            alarm_mem_q <= 1'b0;
            arm_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmr_rst_q   <= tmr_rst_d;
            alarm_mem_q <= alarm_mem_d;
            arm_fail_q  <= arm_fail_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.tmrEN     = timed_s;
    assign bus.tmrRST    = tmr_rst_q;
    assign bus.siren     = (state_q == S_ALARM);
    assign bus.armedLed  = (state_q == S_EXIT) || (state_q == S_ARMED) ||
                           (state_q == S_ENTRY) || (state_q == S_ALARM);
    assign bus.alarmMem  = alarm_mem_q;
    assign bus.armFail   = arm_fail_q;
    assign bus.remaining = timed_s ? (limit_s - cnt_q) : 8'd0;

endmodule
